// File: rtl/priority_encoder_rr_if.sv
// Request/grant bundle for the round-robin priority encoder.
// The master drives the request vector and controls; the slave returns the registered grant.
interface priority_encoder_rr_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic             en;
    logic             mode;
    logic [N-1:0]     in;
    logic [IDX_W-1:0] out;
    logic             valid;

    modport master (
        output en,
        output mode,
        output in,
        input  out,
        input  valid
    );

    modport slave (
        input  en,
        input  mode,
        input  in,
        output out,
        output valid
    );
endinterface

// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with a fixed-priority mode (highest index wins)
// and a round-robin mode that searches downward from a rotating pointer.
module priority_encoder_rr #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input logic                  clk,
    input logic                  rst,
    priority_encoder_rr_if.slave bus
);

    if (IDX_W != $clog2(N)) begin : g_bad_idx_w
        $error("priority_encoder_rr: IDX_W must equal clog2(N)");
    end
    if ((N < 2) || (N > 64)) begin : g_bad_n
        $error("priority_encoder_rr: N must be in 2..64");
    end

    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N - 1);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] fix_idx;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] grant;
    logic             any_req;

    // Fixed priority: the last set bit seen in an ascending scan is the highest index.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.in[i]) begin
                fix_idx = IDX_W'(i);
            end
        end
    end

    // Round-robin: scan from furthest (ptr+1) to nearest (ptr) so ptr itself has final say.
    always_comb begin
        rr_idx = '0;
        cand   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) - k + N) % N);
            if (bus.in[cand]) begin
                rr_idx = cand;
            end
        end
    end

    assign any_req  = |bus.in;
    assign grant    = bus.mode ? rr_idx : fix_idx;
    assign next_ptr = (rr_idx == '0) ? PTR_RESET : rr_idx - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out   <= '0;
            bus.valid <= 1'b0;
            ptr       <= PTR_RESET;
        end else if (bus.en) begin
            if (any_req) begin
                bus.out   <= grant;
                bus.valid <= 1'b1;
                if (bus.mode) begin
                    ptr <= next_ptr;
                end
            end else begin
                bus.out   <= '0;
                bus.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed bench for priority_encoder_rr: a vector table for walks and held patterns,
// followed by hand-written multi-cycle sequences for freeze, reset and mode switching.
module tb_priority_encoder_rr;

    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic [7:0] in;
        logic [2:0] exp_out;
        logic       exp_valid;
        string      name;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    vec_t vecs[$];

    priority_encoder_rr_if #(.N(8), .IDX_W(3)) bus ();

    priority_encoder_rr #(.N(8), .IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input logic r, input logic e, input logic m,
                                   input logic [7:0] i, input logic [2:0] eo,
                                   input logic ev, input string n);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.in = i;
        v.exp_out = eo; v.exp_valid = ev; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic m, input logic [7:0] i);
        rst      = r;
        bus.en   = e;
        bus.mode = m;
        bus.in   = i;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string n, input logic [2:0] eo, input logic ev);
        checks++;
        if (bus.out !== eo) begin
            errors++;
            $display("[TB] FAIL %s out: got %0d expected %0d", n, bus.out, eo);
        end
        checks++;
        if (bus.valid !== ev) begin
            errors++;
            $display("[TB] FAIL %s valid: got %0b expected %0b", n, bus.valid, ev);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic m, input logic [7:0] i,
                        input string n, input logic [2:0] eo, input logic ev);
        applyStimulus(r, e, m, i);
        checkOutput(n, eo, ev);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.mode = 1'b0;
        bus.in   = 8'h00;

        addVec(1, 0, 0, 8'h00, 3'd0, 0, "reset");
        addVec(1, 1, 1, 8'hFF, 3'd0, 0, "reset over en");
        addVec(0, 0, 0, 8'hFF, 3'd0, 0, "hold until en");
        for (int i = 0; i < 8; i++)
            addVec(0, 1, 0, 8'(1 << i), 3'(i), 1, $sformatf("walk fixed bit%0d", i));
        addVec(0, 1, 0, 8'h00, 3'd0, 0, "zero fixed");
        for (int i = 0; i < 8; i++)
            addVec(0, 1, 1, 8'(1 << i), 3'(i), 1, $sformatf("walk rr bit%0d", i));
        addVec(0, 1, 1, 8'h00, 3'd0, 0, "zero rr");
        addVec(1, 1, 0, 8'h00, 3'd0, 0, "reset before fixed hold");
        for (int i = 0; i < 10; i++)
            addVec(0, 1, 0, 8'b0010_1100, 3'd5, 1, $sformatf("fixed hold %0d", i));
        // ptr must still be 7 after the fixed grants, so the rr sweep starts at 7
        for (int i = 0; i < 8; i++)
            addVec(0, 1, 1, 8'hFF, 3'(7 - i), 1, $sformatf("rr sweep %0d", i));
        addVec(0, 1, 1, 8'hFF, 3'd7, 1, "rr sweep wrap");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].in);
            checkOutput(vecs[i].name, vecs[i].exp_out, vecs[i].exp_valid);
        end

        // Alternating pair, then freeze with an input that would otherwise grant 6
        step(1, 1, 1, 8'h00, "alt reset", 3'd0, 0);
        step(0, 1, 1, 8'h81, "alt 0", 3'd7, 1);
        step(0, 1, 1, 8'h81, "alt 1", 3'd0, 1);
        step(0, 1, 1, 8'h81, "alt 2", 3'd7, 1);
        step(0, 1, 1, 8'h81, "alt 3", 3'd0, 1);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 8'h40, $sformatf("freeze %0d", i), 3'd0, 1);
        step(0, 1, 1, 8'h81, "resume 0", 3'd7, 1);
        step(0, 1, 1, 8'h81, "resume 1", 3'd0, 1);

        // Reset mid-sequence restarts the rotation at the top
        step(1, 1, 1, 8'h00, "mid reset init", 3'd0, 0);
        step(0, 1, 1, 8'hFF, "pre reset 7", 3'd7, 1);
        step(0, 1, 1, 8'hFF, "pre reset 6", 3'd6, 1);
        step(0, 1, 1, 8'hFF, "pre reset 5", 3'd5, 1);
        step(1, 1, 1, 8'hFF, "mid reset", 3'd0, 0);
        step(0, 1, 1, 8'hFF, "post reset 7", 3'd7, 1);
        step(0, 1, 1, 8'hFF, "post reset 6", 3'd6, 1);

        // Mode switching keeps ptr; an empty rr request leaves it untouched
        step(1, 1, 1, 8'h00, "mode reset", 3'd0, 0);
        step(0, 1, 1, 8'hFF, "mode rr 7", 3'd7, 1);
        step(0, 1, 1, 8'hFF, "mode rr 6", 3'd6, 1);
        step(0, 1, 0, 8'hFF, "mode fixed 7", 3'd7, 1);
        step(0, 1, 1, 8'hFF, "mode rr 5", 3'd5, 1);
        step(0, 1, 1, 8'h00, "mode rr empty", 3'd0, 0);
        step(0, 1, 1, 8'hFF, "mode rr 4", 3'd4, 1);
        step(0, 1, 1, 8'b0100_0100, "rr wrap search", 3'd2, 1);
        step(0, 1, 1, 8'b0100_0100, "rr wrap search 2", 3'd6, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_encoder_rr.md
PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 Parameter N, default 8: number of request inputs; legal range 2..64.
REQ-002 Parameter IDX_W, default 3: index width; SHALL equal clog2(N), otherwise elaboration error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  sample enable; when 0, all state and outputs hold.
REQ-006 mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 in  input  N  request vector; bit i set = request i active.
REQ-008 out  output  IDX_W  registered index of winning request.
REQ-009 valid  output  1  registered; 1 = at least one request was set in the sampled vector.

Function
REQ-010 Latency SHALL be exactly one cycle: in/mode sampled at edge k with en=1 produce out/valid visible after edge k.
REQ-011 Fixed mode SHALL grant the highest-index set bit of in.
REQ-012 Round-robin mode SHALL search downward from internal pointer ptr: ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set bit wins.
REQ-013 ptr SHALL be IDX_W bits, with reset value N-1.
REQ-014 On a round-robin grant g with en=1, ptr SHALL become g-1; if g=0, ptr SHALL wrap to N-1.
REQ-015 Fixed-mode grants SHALL NOT modify ptr.
REQ-016 in all-zero with en=1 SHALL produce valid=0 and out=0, with ptr unchanged, in either mode.
REQ-017 A mode change SHALL take effect on the sampling edge; ptr is retained across mode changes.
REQ-018 A single set bit SHALL produce that bit's index in both modes, independent of ptr.
REQ-019 en=0 SHALL freeze out, valid and ptr regardless of in, mode and ptr contents.
REQ-020 Round-robin with all N bits held set SHALL cycle grants N-1, N-2, ..., 0, N-1 with no skip or repeat.
REQ-021 Searches and the ptr update SHALL be combinational within one cycle; no multicycle paths.
REQ-022 The output SHALL NOT be an unknown value after reset for any in value, including X-free all-zero input.

Reset
REQ-023 With rst=1 at an edge: out=0, valid=0, ptr=N-1 after that edge.
REQ-024 rst SHALL take priority over en.
REQ-025 A reset mid-sequence discards any pending grant, and the first post-reset round-robin grant equals the fixed-priority result.
REQ-026 Outputs SHALL hold reset values until the first edge with rst=0 and en=1.

Verification
REQ-027 Reset, then walk a single 1 across in[0..7] in each mode (N=8, en=1) -> out=0..7, valid=1, each one cycle later; in=8'h00 -> out=0, valid=0.
REQ-028 mode=0, in=8'b00101100 -> out=5, valid=1; repeat for 10 cycles -> always 5, ptr stays 7.
REQ-029 mode=1, in=8'hFF held 9 cycles -> out sequence 7,6,5,4,3,2,1,0,7.
REQ-030 mode=1, in=8'b10000001 held -> out alternates 7,0,7,0; then en=0 for 3 cycles -> out frozen; en=1 -> sequence resumes without skip.
REQ-031 mode=1, in=8'hFF for 3 grants (7,6,5), then assert rst for 1 cycle -> out=0, valid=0; then in=8'hFF -> next grant 7.
REQ-032 mode=1 for 2 grants (7,6), switch to mode=0 with in=8'hFF -> out=7; switch back to mode=1 -> next grant 5.
